// File: rtl/module_pipe_adder_pkg.sv
// Shared types and helpers for the pipelined adder: operation modes and the
// mapping from a mode to the effective B operand and slice-0 carry-in.
package module_pipe_adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ADC = 2'b10,
    MODE_SBB = 2'b11
  } mode_e;

  // Widest operand the helper below can carry; callers zero-extend into it
  // and slice the low bits back out.
  localparam int MAX_WIDTH = 128;

  // Returns {effective B, carry-in}. Subtraction is A + ~B + cin, so SUB
  // forces cin=1 (no borrow) while SBB takes the caller's inverted borrow.
  function automatic logic [MAX_WIDTH:0] eff_b_cin(input mode_e mode,
                                                   input logic [MAX_WIDTH-1:0] b,
                                                   input logic carry);
    logic [MAX_WIDTH:0] r;
    r = {b, 1'b0};
    case (mode)
      MODE_ADD: r = {b, 1'b0};
      MODE_SUB: r = {~b, 1'b1};
      MODE_ADC: r = {b, carry};
      MODE_SBB: r = {~b, carry};
      default:  r = {b, 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/module_pipe_adder_if.sv
// Handshake and data bundle of the pipelined adder. The adder itself is the
// slave side; whoever issues operands and consumes results is the master.
interface module_pipe_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_bit1;
  logic [WIDTH-1:0] i_bit2;
  logic             i_carry;
  logic [1:0]       i_mode;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_ovf;

  modport slave (
    input  i_valid, i_bit1, i_bit2, i_carry, i_mode, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_ovf
  );

  modport master (
    output i_valid, i_bit1, i_bit2, i_carry, i_mode, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_ovf
  );
endinterface

// File: rtl/module_pipe_adder_slice.sv
// One SW-bit slice of the pipelined adder: a registered add with carry-in,
// carry-out and an overflow flag built from the carry into the slice MSB.
// Only the top slice's overflow is meaningful to the enclosing adder.
module module_pipe_adder_slice #(
  parameter int SW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_ovf
);

  logic [SW:0] full;
  logic        msb_cin;

  // Slice sum; the carry into the MSB falls out of sum = a ^ b ^ carry_in.
  always_comb begin
    full    = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};
    msb_cin = i_a[SW-1] ^ i_b[SW-1] ^ full[SW-1];
  end

  // Result register; frozen while the pipeline is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum  <= '0;
      o_cout <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (i_en) begin
      o_sum  <= full[SW-1:0];
      o_cout <= full[SW];
      o_ovf  <= msb_cin ^ full[SW];
    end
  end

endmodule

// File: rtl/module_pipe_adder.sv
// Carry-pipelined adder/subtractor. Level k adds slice k using the carry
// registered by level k-1; operands are skewed forward and finished low
// slices are carried alongside so the whole result leaves level STAGES-1
// together. WIDTH must be a multiple of STAGES.
module module_pipe_adder
  import module_pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  module_pipe_adder_if.slave bus
);

  localparam int SW = WIDTH / STAGES;

  logic                 en;
  logic [MAX_WIDTH:0]   eff;
  logic [WIDTH-1:0]     b_in;
  logic                 cin_in;

  logic                 vld        [STAGES];
  logic [WIDTH-1:0]     a_stage    [STAGES];  // operands as seen by slice k
  logic [WIDTH-1:0]     b_stage    [STAGES];
  logic                 cin_stage  [STAGES];
  logic [SW-1:0]        slice_sum  [STAGES];
  logic                 slice_cout [STAGES];
  logic                 slice_ovf  [STAGES];
  logic [WIDTH-1:0]     res_full   [STAGES];  // slices 0..k of one result

  // The only stall source is a result waiting on the consumer; the whole
  // pipeline advances together otherwise, so bubbles drain naturally.
  assign en          = bus.i_ready || !vld[STAGES-1];
  assign bus.o_ready = en;

  assign eff    = eff_b_cin(mode_e'(bus.i_mode), MAX_WIDTH'(bus.i_bit2), bus.i_carry);
  assign b_in   = eff[WIDTH:1];
  assign cin_in = eff[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign a_stage[gi]   = bus.i_bit1;
      assign b_stage[gi]   = b_in;
      assign cin_stage[gi] = cin_in;
      assign res_full[gi]  = WIDTH'(slice_sum[gi]);

      // Level-0 valid captures the accepted input.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  vld[gi] <= 1'b0;
        else if (en)   vld[gi] <= bus.i_valid;
      end
    end else begin : g_next
      logic [WIDTH-1:0] lo_reg;

      assign cin_stage[gi] = slice_cout[gi-1];
      assign res_full[gi]  = lo_reg | (WIDTH'(slice_sum[gi]) << (gi * SW));

      // Valid bit follows its operation down the pipe.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  vld[gi] <= 1'b0;
        else if (en)   vld[gi] <= vld[gi-1];
      end

      // Operand skew: upper slices see their bits one level later; no reset
      // needed because the valid bits qualify them.
      always_ff @(posedge i_clk) begin
        if (en) begin
          a_stage[gi] <= a_stage[gi-1];
          b_stage[gi] <= b_stage[gi-1];
        end
      end

      // Result de-skew: carry already-finished low slices beside the operation.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  lo_reg <= '0;
        else if (en)   lo_reg <= res_full[gi-1];
      end
    end

    module_pipe_adder_slice #(.SW(SW)) u_slice (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (en),
      .i_a     (a_stage[gi][gi*SW +: SW]),
      .i_b     (b_stage[gi][gi*SW +: SW]),
      .i_cin   (cin_stage[gi]),
      .o_sum   (slice_sum[gi]),
      .o_cout  (slice_cout[gi]),
      .o_ovf   (slice_ovf[gi])
    );
  end

  assign bus.o_valid = vld[STAGES-1];
  assign bus.o_sum   = res_full[STAGES-1];
  assign bus.o_carry = slice_cout[STAGES-1];
  assign bus.o_ovf   = slice_ovf[STAGES-1];

endmodule

// File: tb/tb_module_pipe_adder.sv
// Bench for the pipelined adder: a directed 16/4 instance for the named
// corner cases, plus four randomly driven instances of different geometry
// checked against a plain-arithmetic reference model through scoreboards.
module tb_module_pipe_adder;
  import module_pipe_adder_pkg::*;

  int   checks   = 0;
  int   failures = 0;
  logic clk      = 1'b0;
  logic rst_d;
  logic rst_r;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- directed instance, WIDTH=16 STAGES=4 ----------------
  module_pipe_adder_if #(.WIDTH(16)) if_d ();
  module_pipe_adder #(.WIDTH(16), .STAGES(4)) dut_d (
    .i_clk   (clk),
    .i_rst_n (rst_d),
    .bus     (if_d)
  );

  logic [17:0] q_d [$];
  int          rcv_d = 0;
  logic        stall_prev_d = 1'b0;
  logic [17:0] held_d;

  // Monitor: pops and compares on every transfer, checks hold during stalls.
  initial forever begin
    @(negedge clk);
    if (!rst_d) begin
      stall_prev_d = 1'b0;
    end else begin
      if (stall_prev_d)
        check("stall_hold_d", {if_d.o_valid, if_d.o_ovf, if_d.o_carry, if_d.o_sum}, {1'b1, held_d});
      if (if_d.o_valid && !if_d.i_ready) begin
        check("stall_ready_d", if_d.o_ready, 1'b0);
        stall_prev_d = 1'b1;
        held_d       = {if_d.o_ovf, if_d.o_carry, if_d.o_sum};
      end else begin
        stall_prev_d = 1'b0;
      end
      if (if_d.o_valid && if_d.i_ready) begin
        check("result_pending_d", q_d.size() > 0, 1'b1);
        if (q_d.size() > 0) begin
          logic [17:0] e;
          e = q_d.pop_front();
          rcv_d++;
          $display("[dir] result #%0d sum=%h carry=%b ovf=%b", rcv_d, if_d.o_sum, if_d.o_carry, if_d.o_ovf);
          check("result_d", {if_d.o_ovf, if_d.o_carry, if_d.o_sum}, e);
        end
      end
    end
  end

  // Presents one operation and waits (bounded) for its acceptance.
  task automatic send_d(input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [17:0] exp, output int tries);
    bit acc = 1'b0;
    tries = 0;
    if_d.i_valid = 1'b1;
    if_d.i_mode  = mode;
    if_d.i_bit1  = a;
    if_d.i_bit2  = b;
    if_d.i_carry = c;
    for (int t = 0; t < 50 && !acc; t++) begin
      tries++;
      @(negedge clk);
      if (if_d.o_ready) begin
        q_d.push_back(exp);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("accept_d", acc, 1'b1);
  endtask

  // ---------------- random instances of several geometries ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : gen_rnd
    localparam int W = (gi == 0) ? 16 : (gi == 1) ? 8 : (gi == 2) ? 32 : 12;
    localparam int S = (gi == 0) ? 4  : (gi == 1) ? 8 : (gi == 2) ? 1  : 3;
    localparam int N = 200;

    module_pipe_adder_if #(.WIDTH(W)) if_r ();
    module_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_r),
      .bus     (if_r)
    );

    logic [W+1:0] q [$];
    int           sent = 0;
    int           rcv  = 0;
    bit           done = 1'b0;
    logic         stall_prev = 1'b0;
    logic [W+1:0] held;

    // Reference: signed/unsigned integer arithmetic; returns {ovf, carry, sum}.
    function automatic logic [W+1:0] ref_model(input logic [1:0] mode, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic c);
      longint ua, ub, sa, sb, ures, sres, lim;
      bit     is_sub, carry, ovf;
      int     cin;
      is_sub = (mode == 2'b01) || (mode == 2'b11);
      cin    = (mode == 2'b00) ? 0 : (mode == 2'b01) ? 1 : int'(c);
      ua = a;
      ub = b;
      sa = a[W-1] ? ua - (longint'(1) << W) : ua;
      sb = b[W-1] ? ub - (longint'(1) << W) : ub;
      if (is_sub) begin
        ures  = ua - ub - (1 - cin);
        sres  = sa - sb - (1 - cin);
        carry = (ures >= 0);
      end else begin
        ures  = ua + ub + cin;
        sres  = sa + sb + cin;
        carry = (ures >= (longint'(1) << W));
      end
      lim = longint'(1) << (W - 1);
      ovf = (sres >= lim) || (sres < -lim);
      return {ovf, carry, ures[W-1:0]};
    endfunction

    // Driver: random operands, modes, valid and ready every cycle.
    initial begin
      if_r.i_valid = 1'b0;
      if_r.i_bit1  = '0;
      if_r.i_bit2  = '0;
      if_r.i_carry = 1'b0;
      if_r.i_mode  = 2'b00;
      if_r.i_ready = 1'b1;
      wait (rst_r === 1'b1);
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 5000 && sent < N; cyc++) begin
        if_r.i_valid = ($urandom_range(3) != 0);
        if_r.i_bit1  = W'($urandom);
        if_r.i_bit2  = W'($urandom);
        if_r.i_carry = 1'($urandom);
        if_r.i_mode  = 2'($urandom);
        if_r.i_ready = ($urandom_range(2) != 0);
        @(negedge clk);
        if (if_r.i_valid && if_r.o_ready) begin
          q.push_back(ref_model(if_r.i_mode, if_r.i_bit1, if_r.i_bit2, if_r.i_carry));
          sent++;
        end
        @(posedge clk); #1;
      end
      if_r.i_valid = 1'b0;
      if_r.i_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && rcv < N; cyc++) @(posedge clk);
      #1;
      check($sformatf("rnd%0d_count", gi), rcv, N);
      check($sformatf("rnd%0d_drained", gi), q.size(), 0);
      done = 1'b1;
    end

    // Monitor for this instance.
    initial forever begin
      @(negedge clk);
      if (rst_r) begin
        if (stall_prev)
          check($sformatf("rnd%0d_stall_hold", gi),
                {if_r.o_valid, if_r.o_ovf, if_r.o_carry, if_r.o_sum}, {1'b1, held});
        if (if_r.o_valid && !if_r.i_ready) begin
          check($sformatf("rnd%0d_stall_ready", gi), if_r.o_ready, 1'b0);
          stall_prev = 1'b1;
          held       = {if_r.o_ovf, if_r.o_carry, if_r.o_sum};
        end else begin
          stall_prev = 1'b0;
        end
        if (if_r.o_valid && if_r.i_ready) begin
          check($sformatf("rnd%0d_pending", gi), q.size() > 0, 1'b1);
          if (q.size() > 0) begin
            logic [W+1:0] e;
            e = q.pop_front();
            rcv++;
            $display("[rnd%0d W=%0d S=%0d] result #%0d sum=%h carry=%b ovf=%b",
                     gi, W, S, rcv, if_r.o_sum, if_r.o_carry, if_r.o_ovf);
            check($sformatf("rnd%0d_result", gi), {if_r.o_ovf, if_r.o_carry, if_r.o_sum}, e);
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int tries;
    int lat;
    logic [15:0] a, b;

    rst_d = 1'b0;
    rst_r = 1'b0;
    if_d.i_valid = 1'b0;
    if_d.i_bit1  = '0;
    if_d.i_bit2  = '0;
    if_d.i_carry = 1'b0;
    if_d.i_mode  = 2'b00;
    if_d.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", if_d.o_valid, 1'b0);
    check("rst_sum",   if_d.o_sum,   16'h0000);
    check("rst_carry", if_d.o_carry, 1'b0);
    check("rst_ovf",   if_d.o_ovf,   1'b0);
    check("rst_ready", if_d.o_ready, 1'b1);
    rst_d = 1'b1;
    rst_r = 1'b1;
    @(posedge clk); #1;

    // Basic add and its latency.
    send_d(MODE_ADD, 16'h1234, 16'h0FCD, 1'b0, {2'b00, 16'h2201}, tries);
    if_d.i_valid = 1'b0;
    lat = 1;
    while (!if_d.o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 4);
    repeat (3) @(posedge clk); #1;

    // Boundary vectors, mixed modes back to back.
    send_d(MODE_ADD, 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000}, tries);
    send_d(MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000}, tries);
    send_d(MODE_SUB, 16'h0000, 16'h0001, 1'b1, {1'b0, 1'b0, 16'hFFFF}, tries);
    send_d(MODE_SBB, 16'h0005, 16'h0003, 1'b0, {1'b0, 1'b1, 16'h0001}, tries);
    send_d(MODE_ADC, 16'h00FF, 16'h0F00, 1'b1, {1'b0, 1'b0, 16'h1000}, tries);
    send_d(MODE_SUB, 16'h8000, 16'h0001, 1'b0, {1'b1, 1'b1, 16'h7FFF}, tries);
    if_d.i_valid = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("drain_vectors", q_d.size(), 0);

    // Eight back-to-back adds with a three-cycle consumer stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a = 16'(i * 16'h1111);
          b = 16'h0101;
          send_d(MODE_ADD, a, b, 1'b0, {2'b00, 16'(a + b)}, tries);
        end
        if_d.i_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        if_d.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if_d.i_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk); #1;
    check("drain_stall", q_d.size(), 0);
    check("count_after_stall", rcv_d, 15);

    // Reset with operations in flight.
    send_d(MODE_ADD, 16'h0001, 16'h0002, 1'b0, {2'b00, 16'h0003}, tries);
    send_d(MODE_ADD, 16'h0010, 16'h0020, 1'b0, {2'b00, 16'h0030}, tries);
    send_d(MODE_ADD, 16'h0100, 16'h0200, 1'b0, {2'b00, 16'h0300}, tries);
    if_d.i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_valid", if_d.o_valid, 1'b1);
    rst_d = 1'b0;
    q_d.delete();
    #1;
    check("reset_valid_now", if_d.o_valid, 1'b0);
    check("reset_sum_now",   if_d.o_sum,   16'h0000);
    @(posedge clk); #1;
    rst_d = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("no_stale_valid", if_d.o_valid, 1'b0);
    send_d(MODE_SUB, 16'h1000, 16'h0001, 1'b1, {2'b00, 16'h0FFF} | 18'h10000, tries);
    check("first_accept_after_reset", tries, 1);
    if_d.i_valid = 1'b0;
    lat = 1;
    while (!if_d.o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency_after_reset", lat, 4);
    repeat (4) @(posedge clk); #1;
    check("drain_reset", q_d.size(), 0);

    // Wait (bounded) for the random instances.
    for (int t = 0; t < 20000 &&
         !(gen_rnd[0].done && gen_rnd[1].done && gen_rnd[2].done && gen_rnd[3].done); t++)
      @(posedge clk);
    check("random_done",
          gen_rnd[0].done && gen_rnd[1].done && gen_rnd[2].done && gen_rnd[3].done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
